// File: rtl/obi_rr_arbiter_if.sv
// OBI request/response bundle shared by the round-robin arbiter.
// Instantiated once per side: NUM_PORTS=NUM_MGR for the manager bundle
// (per-port fields packed, port i at [i*W +: W]) and NUM_PORTS=1 for the
// single shared subordinate port. Response data/err/rid are one-wide in
// both cases because the arbiter broadcasts them to every manager.
//
// Handshake semantics:
//   address phase transfers in any cycle where req & gnt are both high;
//   a raised req keeps its payload stable until that cycle. The response
//   transfers in any cycle where rvalid & rready are both high; rdata, err
//   and rid are only meaningful while rvalid is high.
interface obi_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS = 1,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned IDW       = 1
);
  // Request channel, driven by the manager side
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS*AW-1:0]     addr;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*DW/8-1:0]   be;
  logic [NUM_PORTS*DW-1:0]     wdata;
  logic [NUM_PORTS*IDW-1:0]    aid;
  logic [NUM_PORTS-1:0]        rready;

  // Response channel, driven by the subordinate side
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DW-1:0]               rdata;
  logic                        err;
  logic [IDW-1:0]              rid;

  modport master (
    output req, addr, we, be, wdata, aid, rready,
    input  gnt, rvalid, rdata, err, rid
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, rready,
    output gnt, rvalid, rdata, err, rid
  );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate port between NUM_MGR
// manager ports with a single outstanding transaction.
// Flow: IDLE picks a winner (registered), ADDR forwards the winner's
// address phase with gnt passed straight back, RESP passes the response
// straight through until rvalid & rready, then the priority pointer moves
// to the manager after the one just served.
module obi_rr_arbiter #(
  parameter int unsigned NUM_MGR = 2,
  parameter int unsigned OBI_AW  = 32,
  parameter int unsigned OBI_DW  = 32,
  parameter int unsigned OBI_IDW = 1,
  localparam int unsigned SEL_W  = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  obi_rr_arbiter_if.slave  mgr,
  obi_rr_arbiter_if.master sub,
  output logic             busy,
  output logic [1:0]       dbg_state_o,
  output logic [SEL_W-1:0] dbg_sel_o,
  output logic [SEL_W-1:0] dbg_ptr_o
);

  localparam int unsigned OBI_BW = OBI_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Round-robin search results
  logic             rr_found;
  logic [SEL_W-1:0] rr_pick;
  logic [SEL_W-1:0] ptr_nxt;

  // Fields of the currently selected manager
  logic [OBI_AW-1:0]  sel_addr;
  logic               sel_we;
  logic [OBI_BW-1:0]  sel_be;
  logic [OBI_DW-1:0]  sel_wdata;
  logic [OBI_IDW-1:0] sel_aid;
  logic               sel_req;
  logic               sel_rready;
  logic [NUM_MGR-1:0] sel_oh;

  logic in_addr;
  logic in_resp;

  assign in_addr = (state_q == ST_ADDR);
  assign in_resp = (state_q == ST_RESP);

  // Round-robin winner: first set request at or above ptr, otherwise the
  // lowest set request below ptr. Two linear passes keep the wrap explicit
  // for any NUM_MGR, power of two or not.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (!rr_found && mgr.req[i] && (SEL_W'(i) >= ptr_q)) begin
        rr_found = 1'b1;
        rr_pick  = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_MGR; i++) begin
      if (!rr_found && mgr.req[i]) begin
        rr_found = 1'b1;
        rr_pick  = SEL_W'(i);
      end
    end
  end

  // Pointer after serving sel: the next manager, wrapping at NUM_MGR-1
  assign ptr_nxt = (sel_q == SEL_W'(NUM_MGR - 1)) ? '0 : (sel_q + SEL_W'(1));

  // Select the winner's request fields and build its one-hot mask
  always_comb begin
    sel_addr   = '0;
    sel_we     = 1'b0;
    sel_be     = '0;
    sel_wdata  = '0;
    sel_aid    = '0;
    sel_req    = 1'b0;
    sel_rready = 1'b0;
    sel_oh     = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_addr   = mgr.addr[i*OBI_AW +: OBI_AW];
        sel_we     = mgr.we[i];
        sel_be     = mgr.be[i*OBI_BW +: OBI_BW];
        sel_wdata  = mgr.wdata[i*OBI_DW +: OBI_DW];
        sel_aid    = mgr.aid[i*OBI_IDW +: OBI_IDW];
        sel_req    = mgr.req[i];
        sel_rready = mgr.rready[i];
        sel_oh[i]  = 1'b1;
      end
    end
  end

  // FSM next state; sel is captured only in IDLE, ptr moves only on a
  // completed response handshake
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          sel_d   = rr_pick;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (sub.gnt[0]) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (sub.rvalid[0] && sel_rready) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_nxt;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, winner and pointer registers; reset abandons any transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Address phase toward the shared port: only driven in ADDR
  assign sub.req    = in_addr;
  assign sub.addr   = in_addr ? sel_addr  : '0;
  assign sub.we     = in_addr ? sel_we    : 1'b0;
  assign sub.be     = in_addr ? sel_be    : '0;
  assign sub.wdata  = in_addr ? sel_wdata : '0;
  assign sub.aid    = in_addr ? sel_aid   : '0;

  // Response acceptance: only the winner's rready counts, only in RESP,
  // so a stray rvalid in IDLE or ADDR is never acknowledged
  assign sub.rready = in_resp & sel_rready;

  // Grant and rvalid steered to the winner only
  assign mgr.gnt    = (in_addr && sub.gnt[0])    ? sel_oh : '0;
  assign mgr.rvalid = (in_resp && sub.rvalid[0]) ? sel_oh : '0;

  // Response payload broadcast; qualified per manager by rvalid
  assign mgr.rdata  = sub.rdata;
  assign mgr.err    = sub.err;
  assign mgr.rid    = sub.rid;

  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;
  assign dbg_sel_o   = sel_q;
  assign dbg_ptr_o   = ptr_q;

  // A manager must not withdraw its request while it holds the address
  // phase; the arbiter keeps driving s_req with the captured index
  a_req_held_in_addr: assert property (
    @(posedge clk_i) disable iff (rst_i) in_addr |-> sel_req
  );

endmodule
